crc_serial_engine: RTL and testbench
====================================

Name: crc_serial_engine

Overview:
Parametrised bit-serial CRC engine; successor to the fixed 34-bit-data / CRC-16 serial generator. Width, polynomial and init value are generic. Adds a start/busy/done handshake, back-to-back frame support, and a check mode that verifies a received CRC. Sits between the frame assembler and the serial link, one frame per start.

Parameters:
DATA_W, 34, payload width in bits (>=1), shifted MSB first
CRC_W, 16, CRC register width (1..32)
POLY, 16'h1021, generator polynomial without the implicit x^CRC_W term
INIT, 16'h0000, CRC register value loaded at start
XOR_OUT, 16'h0000, value XORed into the final register to give crc_out

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state and outputs
start  in  1  frame request; sampled only when busy=0
mode  in  1  0 = generate, 1 = check; latched with start
data_in  in  DATA_W  payload; latched with start
crc_in  in  CRC_W  received CRC (check mode); latched with start, ignored in generate mode
busy  out  1  frame in progress
done  out  1  one-cycle pulse, results valid
crc_out  out  CRC_W  computed CRC (final register ^ XOR_OUT)
data_out  out  DATA_W+CRC_W  codeword {payload, crc_out}
crc_ok  out  1  check mode: crc_out == latched crc_in; 0 in generate mode

Behaviour:
- Reset (async, any time incl. mid-frame): state=IDLE, busy=0, done=0, crc_out=0, data_out=0, crc_ok=0, bit counter=0, shift/CRC registers=0. First edge after deassertion behaves as IDLE.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge E0: latch data_in into shift reg, crc_in, mode; crc_reg<=INIT; cnt<=0; busy<=1; go SHIFT. start=0: hold.
- SHIFT, edges E1..E_DATA_W, one bit per edge, MSB first: fb = shift[DATA_W-1] ^ crc_reg[CRC_W-1]; crc_reg <= (crc_reg<<1) ^ (fb ? POLY : 0); shift <= shift<<1; cnt<=cnt+1.
- Edge E_DATA_W (last bit, cnt==DATA_W-1): register crc_out = next crc_reg ^ XOR_OUT, data_out = {latched payload, that value}, crc_ok = mode & (that value == latched crc_in); done<=1; busy<=0; go IDLE.
- done high exactly one cycle (after E_DATA_W); cleared at next edge unless the frame ends again.
- Latency: start edge to done high = DATA_W edges; min frame period DATA_W+1 cycles.
- start while busy=1: ignored, no effect on current frame or inputs latched.
- start during done cycle (state IDLE): accepted; new frame begins; done still drops next edge.
- data_in/crc_in/mode may change freely after E0.
- crc_out/data_out/crc_ok hold last result until next done edge or reset; not cleared by start.
- cnt width = clog2(DATA_W+1); no wrap possible within a frame.
- POLY/INIT/XOR_OUT truncated to CRC_W bits.

Test Plan:
- Reset: drive reset high between edges mid-frame -> busy, done, crc_out, data_out, crc_ok go 0 immediately, without waiting for a clock edge. Release, start -> frame computes correctly from scratch.
- Generate, DATA_W=8, defaults, data_in=8'h01 -> done 8 edges after start, crc_out=16'h1021, data_out=24'h011021, crc_ok=0, busy high for exactly 8 cycles.
- Generate, DATA_W=72, data_in=ASCII "123456789" -> crc_out=16'h31C3. Same data with INIT=16'hFFFF -> 16'h29B1.
- Check, DATA_W=72, "123456789", crc_in=16'h31C3 -> crc_ok=1. crc_in=16'h31C2 -> crc_ok=0, crc_out still 16'h31C3.
- Handshake, DATA_W=8: start pulsed at cycles 3 and 5 of a frame -> ignored, single done. start held high through the done cycle -> second frame begins immediately, done pulses separated by 9 cycles, second result correct.
- Default config (DATA_W=34, CRC_W=16): 34'h3_FFFF_FFFF generate then check with returned crc_out -> crc_ok=1. Flip any one payload bit with the same crc_in -> crc_ok=0.

Source files
------------

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC engine with start/busy/done handshake and a check mode that
// compares the computed CRC against a received one. One payload bit per clock, MSB first.
module crc_serial_engine #(
  parameter int               DATA_W  = 34,
  parameter int               CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = 16'h1021,
  parameter logic [CRC_W-1:0] INIT    = 16'h0000,
  parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [CRC_W-1:0]         crc_in,
  output logic                     busy,
  output logic                     done,
  output logic [CRC_W-1:0]         crc_out,
  output logic [DATA_W+CRC_W-1:0]  data_out,
  output logic                     crc_ok
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                    state_q, state_d;
  logic [DATA_W-1:0]         shift_q, shift_d;
  logic [CRC_W-1:0]          crc_q, crc_d;
  logic [CRC_W-1:0]          crc_in_q, crc_in_d;
  logic                      mode_q, mode_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [CRC_W-1:0]          crc_out_q, crc_out_d;
  logic [DATA_W+CRC_W-1:0]   data_out_q, data_out_d;
  logic                      crc_ok_q, crc_ok_d;

  logic                      fb;
  logic [CRC_W-1:0]          crc_step;
  logic [CRC_W-1:0]          crc_fin;
  logic [DATA_W-1:0]         shift_rot;

  always_comb begin
    fb        = shift_q[DATA_W-1] ^ crc_q[CRC_W-1];
    crc_step  = (crc_q << 1) ^ (fb ? POLY : '0);
    crc_fin   = crc_step ^ XOR_OUT;
    // Rotating rather than shifting returns the original payload after
    // DATA_W steps, so the codeword needs no separate payload copy.
    shift_rot = (shift_q << 1) | (shift_q >> (DATA_W - 1));

    state_d    = state_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    crc_in_d   = crc_in_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    crc_out_d  = crc_out_q;
    data_out_d = data_out_q;
    crc_ok_d   = crc_ok_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d  = data_in;
          crc_in_d = crc_in;
          mode_d   = mode;
          crc_d    = INIT;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        crc_d   = crc_step;
        shift_d = shift_rot;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          crc_out_d  = crc_fin;
          data_out_d = {shift_rot, crc_fin};
          crc_ok_d   = mode_q & (crc_fin == crc_in_q);
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      crc_q      <= '0;
      crc_in_q   <= '0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crc_out_q  <= '0;
      data_out_q <= '0;
      crc_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      crc_q      <= crc_d;
      crc_in_q   <= crc_in_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crc_out_q  <= crc_out_d;
      data_out_q <= data_out_d;
      crc_ok_q   <= crc_ok_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign crc_out  = crc_out_q;
  assign data_out = data_out_q;
  assign crc_ok   = crc_ok_q;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine: four instances cover DATA_W=8, 72
// (INIT 0 and FFFF) and the default 34/16 configuration.
module tb_crc_serial_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // DATA_W=8
  logic        s8_start = 0, s8_mode = 0, s8_busy, s8_done, s8_ok;
  logic [7:0]  s8_data = '0;
  logic [15:0] s8_crcin = '0, s8_crc;
  logic [23:0] s8_dout;
  // DATA_W=72, INIT=0
  logic        sa_start = 0, sa_mode = 0, sa_busy, sa_done, sa_ok;
  logic [71:0] sa_data = '0;
  logic [15:0] sa_crcin = '0, sa_crc;
  logic [87:0] sa_dout;
  // DATA_W=72, INIT=FFFF
  logic        sb_start = 0, sb_mode = 0, sb_busy, sb_done, sb_ok;
  logic [71:0] sb_data = '0;
  logic [15:0] sb_crcin = '0, sb_crc;
  logic [87:0] sb_dout;
  // defaults
  logic        sd_start = 0, sd_mode = 0, sd_busy, sd_done, sd_ok;
  logic [33:0] sd_data = '0;
  logic [15:0] sd_crcin = '0, sd_crc;
  logic [49:0] sd_dout;

  localparam logic [71:0] ASCII_9 = 72'h313233343536373839;

  crc_serial_engine #(.DATA_W(8)) u8 (
    .clk(clk), .reset(reset), .start(s8_start), .mode(s8_mode), .data_in(s8_data),
    .crc_in(s8_crcin), .busy(s8_busy), .done(s8_done), .crc_out(s8_crc),
    .data_out(s8_dout), .crc_ok(s8_ok));

  crc_serial_engine #(.DATA_W(72)) ua (
    .clk(clk), .reset(reset), .start(sa_start), .mode(sa_mode), .data_in(sa_data),
    .crc_in(sa_crcin), .busy(sa_busy), .done(sa_done), .crc_out(sa_crc),
    .data_out(sa_dout), .crc_ok(sa_ok));

  crc_serial_engine #(.DATA_W(72), .INIT(16'hFFFF)) ub (
    .clk(clk), .reset(reset), .start(sb_start), .mode(sb_mode), .data_in(sb_data),
    .crc_in(sb_crcin), .busy(sb_busy), .done(sb_done), .crc_out(sb_crc),
    .data_out(sb_dout), .crc_ok(sb_ok));

  crc_serial_engine ud (
    .clk(clk), .reset(reset), .start(sd_start), .mode(sd_mode), .data_in(sd_data),
    .crc_in(sd_crcin), .busy(sd_busy), .done(sd_done), .crc_out(sd_crc),
    .data_out(sd_dout), .crc_ok(sd_ok));

  // Caller raises start at a negedge; this drops it one cycle later and
  // returns edges from start to done (-1 on timeout) and busy cycles seen.
  task automatic run(input int which, output int lat, output int bcyc);
    int n;
    logic d, b;
    n = 0; bcyc = 0; lat = -1;
    while (n < 200 && lat < 0) begin
      @(negedge clk);
      n++;
      case (which)
        0: begin s8_start = 0; d = s8_done; b = s8_busy; end
        1: begin sa_start = 0; d = sa_done; b = sa_busy; end
        2: begin sb_start = 0; d = sb_done; b = sb_busy; end
        default: begin sd_start = 0; d = sd_done; b = sd_busy; end
      endcase
      if (b) bcyc++;
      if (d) lat = n - 1;
    end
  endtask

  task automatic test_reset;
    int lat, bc;
    total++;
    if ({s8_busy, s8_done, s8_ok, s8_crc, s8_dout} !== '0) begin
      bad++; $display("FAIL reset_init: got %h want 0", {s8_busy, s8_done, s8_ok, s8_crc, s8_dout});
    end
    @(negedge clk); reset = 0;
    @(negedge clk); s8_data = 8'h01; s8_start = 1;
    run(0, lat, bc);
    @(negedge clk); s8_data = 8'h01; s8_start = 1;
    repeat (3) @(negedge clk);
    s8_start = 0;
    total++;
    if (s8_busy !== 1'b1 || s8_crc !== 16'h1021) begin
      bad++; $display("FAIL reset_pre: busy=%b crc=%h want 1/1021", s8_busy, s8_crc);
    end
    #2 reset = 1;
    #1;
    total++;
    if ({s8_busy, s8_done, s8_ok, s8_crc, s8_dout} !== '0) begin
      bad++; $display("FAIL reset_async: got %h want 0", {s8_busy, s8_done, s8_ok, s8_crc, s8_dout});
    end
    @(negedge clk); reset = 0;
    s8_data = 8'h01; s8_start = 1;
    run(0, lat, bc);
    total++;
    if (lat !== 8 || s8_crc !== 16'h1021) begin
      bad++; $display("FAIL reset_recover: lat=%0d crc=%h want 8/1021", lat, s8_crc);
    end
  endtask

  task automatic test_generate8;
    int lat, bc;
    @(negedge clk); s8_data = 8'h01; s8_mode = 0; s8_start = 1;
    run(0, lat, bc);
    total++;
    if (lat !== 8 || bc !== 8) begin
      bad++; $display("FAIL gen8_timing: lat=%0d busy=%0d want 8/8", lat, bc);
    end
    total++;
    if (s8_crc !== 16'h1021 || s8_dout !== 24'h011021 || s8_ok !== 1'b0) begin
      bad++; $display("FAIL gen8_result: crc=%h dout=%h ok=%b want 1021/011021/0", s8_crc, s8_dout, s8_ok);
    end
    @(negedge clk);
    total++;
    if (s8_done !== 1'b0 || s8_crc !== 16'h1021) begin
      bad++; $display("FAIL gen8_pulse: done=%b crc=%h want 0/1021", s8_done, s8_crc);
    end
  endtask

  task automatic test_crc72;
    int lat, bc;
    @(negedge clk); sa_data = ASCII_9; sa_mode = 0; sa_crcin = 16'h31C3; sa_start = 1;
    run(1, lat, bc);
    total++;
    if (lat !== 72 || sa_crc !== 16'h31C3 || sa_ok !== 1'b0 || sa_dout !== {ASCII_9, 16'h31C3}) begin
      bad++; $display("FAIL gen72: lat=%0d crc=%h ok=%b want 72/31c3/0", lat, sa_crc, sa_ok);
    end
    @(negedge clk); sb_data = ASCII_9; sb_mode = 0; sb_start = 1;
    run(2, lat, bc);
    total++;
    if (sb_crc !== 16'h29B1) begin
      bad++; $display("FAIL gen72_init: crc=%h want 29b1", sb_crc);
    end
  endtask

  task automatic test_check72;
    int lat, bc;
    @(negedge clk); sa_data = ASCII_9; sa_mode = 1; sa_crcin = 16'h31C3; sa_start = 1;
    @(negedge clk); sa_start = 0; sa_crcin = 16'h0000; sa_mode = 0; sa_data = '0;
    run(1, lat, bc);
    total++;
    if (sa_ok !== 1'b1 || sa_crc !== 16'h31C3) begin
      bad++; $display("FAIL chk72_good: ok=%b crc=%h want 1/31c3", sa_ok, sa_crc);
    end
    @(negedge clk); sa_data = ASCII_9; sa_mode = 1; sa_crcin = 16'h31C2; sa_start = 1;
    run(1, lat, bc);
    total++;
    if (sa_ok !== 1'b0 || sa_crc !== 16'h31C3) begin
      bad++; $display("FAIL chk72_bad: ok=%b crc=%h want 0/31c3", sa_ok, sa_crc);
    end
  endtask

  task automatic test_handshake;
    int n, dones, t1, t2;
    @(negedge clk); s8_data = 8'h01; s8_mode = 0; s8_start = 1;
    dones = 0; t1 = -1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      s8_start = (i == 3 || i == 5);
      if (i == 3) begin s8_data = 8'hFF; s8_mode = 1; s8_crcin = 16'h1021; end
      if (s8_done) begin dones++; t1 = i; end
    end
    total++;
    if (dones !== 1 || t1 !== 9 || s8_crc !== 16'h1021 || s8_ok !== 1'b0) begin
      bad++; $display("FAIL hs_ignore: dones=%0d at=%0d crc=%h ok=%b want 1/9/1021/0", dones, t1, s8_crc, s8_ok);
    end
    s8_start = 0;
    @(negedge clk); s8_data = 8'h01; s8_mode = 0; s8_start = 1;
    dones = 0; t1 = -1; t2 = -1; n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) s8_data = 8'h02;
      if (s8_done) begin
        dones++;
        if (t1 < 0) begin
          t1 = i;
          total++;
          if (s8_crc !== 16'h1021) begin
            bad++; $display("FAIL b2b_first: crc=%h want 1021", s8_crc);
          end
        end else t2 = i;
      end
      if (t1 > 0 && i == t1 + 1) s8_start = 0;
      n = i;
    end
    total++;
    if (dones !== 2 || (t2 - t1) !== 9 || n !== 30) begin
      bad++; $display("FAIL b2b_spacing: dones=%0d gap=%0d want 2/9", dones, t2 - t1);
    end
    total++;
    if (s8_crc !== 16'h2042 || s8_dout !== 24'h022042) begin
      bad++; $display("FAIL b2b_second: crc=%h dout=%h want 2042/022042", s8_crc, s8_dout);
    end
  endtask

  task automatic test_default34;
    int lat, bc;
    logic [33:0] flip;
    @(negedge clk); sd_data = 34'h3_FFFF_FFFF; sd_mode = 0; sd_start = 1;
    run(3, lat, bc);
    total++;
    if (lat !== 34 || sd_crc !== 16'h771D || sd_dout !== {34'h3_FFFF_FFFF, 16'h771D}) begin
      bad++; $display("FAIL d34_gen: lat=%0d crc=%h dout=%h want 34/771d", lat, sd_crc, sd_dout);
    end
    @(negedge clk); sd_mode = 1; sd_crcin = 16'h771D; sd_start = 1;
    run(3, lat, bc);
    total++;
    if (sd_ok !== 1'b1) begin
      bad++; $display("FAIL d34_check: ok=%b want 1", sd_ok);
    end
    for (int k = 0; k < 3; k++) begin
      flip = 34'h3_FFFF_FFFF;
      flip[k * 16 + (k == 2 ? 1 : 0)] = 1'b0;
      @(negedge clk); sd_data = flip; sd_mode = 1; sd_crcin = 16'h771D; sd_start = 1;
      run(3, lat, bc);
      total++;
      if (sd_ok !== 1'b0 || lat !== 34) begin
        bad++; $display("FAIL d34_flip%0d: ok=%b lat=%0d want 0/34", k, sd_ok, lat);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_generate8();
    test_crc72();
    test_check72();
    test_handshake();
    test_default34();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
